// File: rtl/rc4_stream_core.sv
`default_nettype none
// ==========================================================================
// Module   : rc4_stream_core
// Purpose  : RC4 / RC4-drop[N] keystream XOR engine with valid/ready streaming
// Revision : 1.0 - initial release
// ==========================================================================
module rc4_stream_core #(
  parameter int KEY_MAX_LEN = 32,
  parameter int DROP_N      = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             key_valid_i,
  input  logic [7:0]       key_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       out_data_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             key_ovf_o,
  output logic [CNT_W-1:0] byte_cnt_o,
  output logic             done_o
);

  localparam int KI_W = (KEY_MAX_LEN > 1) ? $clog2(KEY_MAX_LEN) : 1;
  localparam int DC_W = (DROP_N > 1) ? $clog2(DROP_N) : 1;
  localparam logic [8:0]      C_KMAX      = 9'(KEY_MAX_LEN);
  localparam logic [DC_W-1:0] C_DROP_LAST = DC_W'((DROP_N > 0) ? DROP_N - 1 : 0);
  localparam logic [7:0]      C_I_LAST    = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_INIT = 3'd2,
    ST_KSA  = 3'd3,
    ST_DROP = 3'd4,
    ST_RUN  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        i_q, i_d, j_q, j_d;
  logic [KI_W-1:0]   kidx_q, kidx_d;
  logic [8:0]        cnt_q, cnt_d, klen_q, klen_d;
  logic [DC_W-1:0]   drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic              ov_q, ov_d, ol_q, ol_d, done_q, done_d;
  logic [7:0]        od_q, od_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;

  logic [7:0]        w_s [256];
  logic [7:0]        w_k [KEY_MAX_LEN];
  logic              s_init, s_swap, key_we, w_rdy;
  logic [7:0]        s_a, s_b, w_va, w_vb;
  logic [KI_W-1:0]   key_wa;
  logic [7:0]        w_ip, w_jp, w_sa, w_sb, w_t, w_ks, w_ksa_j;

  // S-box cells: a swap writes both addresses; when they coincide both writes agree.
  for (genvar g = 0; g < 256; g++) begin : g_sbox
    logic [7:0] cell_q;
    always_ff @(posedge clk_i) begin
      if (s_init) begin
        cell_q <= 8'(g);
      end else if (s_swap && (s_a == 8'(g))) begin
        cell_q <= w_vb;
      end else if (s_swap && (s_b == 8'(g))) begin
        cell_q <= w_va;
      end
    end
    assign w_s[g] = cell_q;
  end

  for (genvar g = 0; g < KEY_MAX_LEN; g++) begin : g_key
    logic [7:0] kb_q;
    always_ff @(posedge clk_i) begin
      if (key_we && (key_wa == KI_W'(g))) begin
        kb_q <= key_i;
      end
    end
    assign w_k[g] = kb_q;
  end

  assign w_va = w_s[s_a];
  assign w_vb = w_s[s_b];

  // PRGA step from pre-swap values; the keystream byte is looked up as if after the swap.
  always_comb begin
    w_ip = i_q + 8'd1;
    w_sa = w_s[w_ip];
    w_jp = j_q + w_sa;
    w_sb = w_s[w_jp];
    w_t  = w_sa + w_sb;
    if (w_t == w_ip) begin
      w_ks = w_sb;
    end else if (w_t == w_jp) begin
      w_ks = w_sa;
    end else begin
      w_ks = w_s[w_t];
    end
    w_ksa_j = j_q + w_s[i_q] + w_k[kidx_q];
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ol_d    = ol_q;
    bcnt_d  = bcnt_q;
    done_d  = 1'b0;
    s_init  = 1'b0;
    s_swap  = 1'b0;
    s_a     = w_ip;
    s_b     = w_jp;
    key_we  = 1'b0;
    key_wa  = cnt_q[KI_W-1:0];
    w_rdy   = 1'b0;

    case (state_q)
      ST_IDLE: begin
      end
      ST_LOAD: begin
        if (key_valid_i) begin
          if (cnt_q < C_KMAX) begin
            key_we = 1'b1;
            cnt_d  = cnt_q + 9'd1;
          end else begin
            ovf_d  = 1'b1;
          end
        end else begin
          klen_d  = cnt_q;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        s_init  = 1'b1;
        i_d     = 8'd0;
        j_d     = 8'd0;
        kidx_d  = '0;
        bcnt_d  = '0;
        state_d = ST_KSA;
      end
      ST_KSA: begin
        s_swap = 1'b1;
        s_a    = i_q;
        s_b    = w_ksa_j;
        i_d    = i_q + 8'd1;
        j_d    = w_ksa_j;
        if ((9'(kidx_q) + 9'd1) == klen_q) begin
          kidx_d = '0;
        end else begin
          kidx_d = kidx_q + KI_W'(1);
        end
        if (i_q == C_I_LAST) begin
          j_d     = 8'd0;
          drop_d  = '0;
          state_d = (DROP_N > 0) ? ST_DROP : ST_RUN;
        end
      end
      ST_DROP: begin
        s_swap = 1'b1;
        i_d    = w_ip;
        j_d    = w_jp;
        drop_d = drop_q + DC_W'(1);
        if (drop_q == C_DROP_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A pending last byte blocks new input so nothing is accepted into a closing stream.
        w_rdy = (!ov_q || (out_ready_i && !ol_q)) && !key_valid_i;
        if (ov_q && out_ready_i) begin
          bcnt_d = bcnt_q + CNT_W'(1);
          ov_d   = 1'b0;
          if (ol_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        if (in_valid_i && w_rdy) begin
          s_swap = 1'b1;
          i_d    = w_ip;
          j_d    = w_jp;
          od_d   = in_data_i ^ w_ks;
          ol_d   = in_last_i;
          ov_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (key_valid_i && (state_q != ST_LOAD)) begin
      s_init  = 1'b0;
      s_swap  = 1'b0;
      key_we  = 1'b1;
      key_wa  = '0;
      cnt_d   = 9'd1;
      ovf_d   = 1'b0;
      ov_d    = 1'b0;
      ol_d    = 1'b0;
      done_d  = 1'b0;
      state_d = ST_LOAD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      kidx_q  <= '0;
      cnt_q   <= 9'd0;
      klen_q  <= 9'd0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= 8'd0;
      ol_q    <= 1'b0;
      bcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
      bcnt_q  <= bcnt_d;
      done_q  <= done_d;
    end
  end

  assign in_ready_o  = w_rdy;
  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
  assign out_last_o  = ol_q;
  assign key_ovf_o   = ovf_q;
  assign byte_cnt_o  = bcnt_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q == ST_LOAD) || (state_q == ST_INIT) ||
                       (state_q == ST_KSA)  || (state_q == ST_DROP);

endmodule
`default_nettype wire

// File: tb/tb_rc4_stream_core.sv
`default_nettype none
// ==========================================================================
// Module   : tb_rc4_stream_core
// Purpose  : scoreboard bench; instance A default, instance B DROP_N=3/KEY_MAX_LEN=4
// Revision : 1.0 - initial release
// ==========================================================================
module tb_rc4_stream_core;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       sel       = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_data  = 8'd0;
  logic       in_valid  = 1'b0;
  logic [7:0] in_data   = 8'd0;
  logic       in_last   = 1'b0;
  logic       out_ready = 1'b1;
  logic       stall_en  = 1'b0;

  logic        kv [2];
  logic        iv [2];
  logic        rdy [2];
  logic        ov [2];
  logic        ol [2];
  logic        busy [2];
  logic        ovf [2];
  logic        done [2];
  logic [7:0]  od [2];
  logic [15:0] bcnt [2];

  logic [8:0] q_a [$];
  logic [8:0] q_b [$];
  int n_checks = 0;
  int n_errors = 0;

  assign kv[0] = key_valid & ~sel;
  assign kv[1] = key_valid & sel;
  assign iv[0] = in_valid & ~sel;
  assign iv[1] = in_valid & sel;

  always #5 clk = ~clk;

  rc4_stream_core u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .key_valid_i(kv[0]), .key_i(key_data),
    .in_valid_i(iv[0]), .in_ready_o(rdy[0]), .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(ov[0]), .out_ready_i(out_ready), .out_data_o(od[0]), .out_last_o(ol[0]),
    .busy_o(busy[0]), .key_ovf_o(ovf[0]), .byte_cnt_o(bcnt[0]), .done_o(done[0])
  );

  rc4_stream_core #(.KEY_MAX_LEN(4), .DROP_N(3), .CNT_W(16)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .key_valid_i(kv[1]), .key_i(key_data),
    .in_valid_i(iv[1]), .in_ready_o(rdy[1]), .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(ov[1]), .out_ready_i(out_ready), .out_data_o(od[1]), .out_last_o(ol[1]),
    .busy_o(busy[1]), .key_ovf_o(ovf[1]), .byte_cnt_o(bcnt[1]), .done_o(done[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] s2p(input string s);
    logic [127:0] r = '0;
    for (int k = 0; k < s.len() && k < 16; k++) r[127-8*k -: 8] = s[k];
    return r;
  endfunction

  // Reference RC4 for a 4-byte key, returning keystream byte number pos (0-based).
  function automatic logic [7:0] ref_ks(input logic [31:0] key, input int pos);
    logic [7:0] s [256];
    logic [7:0] i, j, t, r;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    j = 8'd0;
    for (int k = 0; k < 256; k++) begin
      j = j + s[k] + key[31-8*(k%4) -: 8];
      t = s[k]; s[k] = s[j]; s[j] = t;
    end
    i = 8'd0; j = 8'd0; r = 8'd0;
    for (int n = 0; n <= pos; n++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[i] + s[j];
      r = s[t];
    end
    return r;
  endfunction

  task automatic load_key(input logic s, input logic [63:0] kb, input int n,
                          input bit wait_rdy, input int exp_lat);
    int lat;
    bit ok;
    sel = s;
    for (int k = 0; k < n; k++) begin
      key_valid = 1'b1;
      key_data  = kb[63-8*k -: 8];
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    if (wait_rdy) begin
      lat = 0;
      ok  = 1'b0;
      while (lat < 1000 && !ok) begin
        @(negedge clk);
        if (lat == 1) chk("busy_during_init", 32'(sel ? busy[1] : busy[0]), 32'd1);
        if (sel ? rdy[1] : rdy[0]) ok = 1'b1;
        else begin
          @(posedge clk); #1;
          lat++;
        end
      end
      chk("key_to_ready_cycles", 32'(lat), 32'(exp_lat));
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [127:0] din, input logic [127:0] dexp,
                      input int n, input bit last);
    for (int k = 0; k < n; k++) begin
      bit acc;
      int c;
      in_valid = 1'b1;
      in_data  = din[127-8*k -: 8];
      in_last  = last && (k == n - 1);
      acc = 1'b0;
      c   = 0;
      while (!acc && c < 2000) begin
        @(negedge clk);
        if (sel ? rdy[1] : rdy[0]) begin
          acc = 1'b1;
          if (sel) q_b.push_back({in_last, dexp[127-8*k -: 8]});
          else     q_a.push_back({in_last, dexp[127-8*k -: 8]});
        end
        @(posedge clk); #1;
        c++;
      end
      if (!acc) begin
        chk("in_ready_timeout", 32'(c), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (c < 2000 && (((sel ? q_b.size() : q_a.size()) != 0) || (sel ? ov[1] : ov[0]))) begin
      @(negedge clk);
      c++;
    end
    if (c >= 2000) chk("drain_timeout", 32'(c), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: output scoreboard, done pulse and stall stability for both instances.
  initial begin
    bit         stl [2];
    bit         pd [2];
    logic [7:0] sd [2];
    logic [8:0] e;
    stl = '{1'b0, 1'b0};
    pd  = '{1'b0, 1'b0};
    sd  = '{8'd0, 8'd0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (pd[d] || done[d]) chk("done_pulse", 32'(done[d]), 32'(pd[d]));
        pd[d] = 1'b0;
        if (stl[d]) begin
          chk("stall_hold_valid", 32'(ov[d]), 32'd1);
          chk("stall_hold_data", 32'(od[d]), 32'(sd[d]));
        end
        stl[d] = ov[d] && !out_ready;
        sd[d]  = od[d];
        if (ov[d] && out_ready) begin
          if ((d == 0 ? q_a.size() : q_b.size()) == 0) begin
            chk("unexpected_output", 32'({ol[d], od[d]}), 32'h1FF);
          end else begin
            e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
            chk("out_last_data", 32'({ol[d], od[d]}), 32'(e));
            pd[d] = e[8];
          end
        end
      end
    end
  end

  initial begin
    logic [127:0] e;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_in_ready", 32'(rdy[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_key_ovf", 32'(ovf[0]), 32'd0);
    chk("rst_byte_cnt", 32'(bcnt[0]), 32'd0);
    chk("rst_out_data", 32'(od[0]), 32'd0);

    load_key(1'b0, {24'h4B6579, 40'h0}, 3, 1'b1, 258);
    send(s2p("Plaintext"), {72'hBBF316E8D940AF0AD3, 56'h0}, 9, 1'b1);
    drain();
    chk("byte_cnt_plaintext", 32'(bcnt[0]), 32'd9);

    load_key(1'b0, {32'h57696B69, 32'h0}, 4, 1'b1, 258);
    send(s2p("pedia"), {40'h1021BF0420, 88'h0}, 5, 1'b1);
    drain();
    load_key(1'b0, {32'h57696B69, 32'h0}, 4, 1'b1, 258);
    send({40'h1021BF0420, 88'h0}, s2p("pedia"), 5, 1'b1);
    drain();

    load_key(1'b0, {48'h536563726574, 16'h0}, 6, 1'b1, 258);
    stall_en = 1'b1;
    send(s2p("Attack at dawn"), {112'h45A01F645FC35B383552544B9BF5, 16'h0}, 14, 1'b1);
    drain();
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("byte_cnt_stalled", 32'(bcnt[0]), 32'd14);

    load_key(1'b1, {48'h4B6579AABBCC, 16'h0}, 6, 1'b1, 261);
    chk("key_ovf_set", 32'(ovf[1]), 32'd1);
    e = '0;
    for (int k = 0; k < 4; k++) e[127-8*k -: 8] = ref_ks(32'h4B6579AA, 3 + k);
    send(128'h0, e, 4, 1'b1);
    drain();
    load_key(1'b1, {24'h4B6579, 40'h0}, 3, 1'b1, 261);
    chk("key_ovf_cleared", 32'(ovf[1]), 32'd0);
    send(128'h0, {48'h81B734CA72A7, 80'h0}, 6, 1'b1);
    drain();

    load_key(1'b0, {48'h536563726574, 16'h0}, 6, 1'b0, 0);
    repeat (100) @(posedge clk);
    #1;
    chk("ksa_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", 32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 32'(rdy[0]), 32'd0);
    chk("post_reset_out_valid", 32'(ov[0]), 32'd0);
    load_key(1'b0, {24'h4B6579, 40'h0}, 3, 1'b1, 258);
    send(s2p("Plaintext"), {72'hBBF316E8D940AF0AD3, 56'h0}, 9, 1'b1);
    drain();

    load_key(1'b0, {32'h57696B69, 32'h0}, 4, 1'b1, 258);
    send(s2p("pe"), {16'h1021, 112'h0}, 2, 1'b0);
    drain();
    chk("byte_cnt_partial", 32'(bcnt[0]), 32'd2);
    load_key(1'b0, {24'h4B6579, 40'h0}, 3, 1'b1, 258);
    chk("byte_cnt_restart", 32'(bcnt[0]), 32'd0);
    send(s2p("Plaintext"), {72'hBBF316E8D940AF0AD3, 56'h0}, 9, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
